// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer.
// Contents:
//   state_t       - sequencer FSM states
//   song_entry_t  - one song ROM entry {note, rest, dur}
//   NOTE_*        - note codes understood by the tone divider (0=do .. 7=high do)
//   make_entry    - helper used to build ROM entries
package tone_pkg;

    localparam int DEFAULT_SONG_LEN = 16;
    localparam int DUR_W            = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]       note;
        logic             rest;
        logic [DUR_W-1:0] dur;   // milliseconds; 0 marks end of song
    } song_entry_t;

    localparam logic [2:0] NOTE_DO    = 3'd0;
    localparam logic [2:0] NOTE_RE    = 3'd1;
    localparam logic [2:0] NOTE_MI    = 3'd2;
    localparam logic [2:0] NOTE_FA    = 3'd3;
    localparam logic [2:0] NOTE_SOL   = 3'd4;
    localparam logic [2:0] NOTE_LA    = 3'd5;
    localparam logic [2:0] NOTE_TI    = 3'd6;
    localparam logic [2:0] NOTE_DO_HI = 3'd7;

    function automatic song_entry_t make_entry(input logic [2:0] note,
                                               input logic rest,
                                               input logic [DUR_W-1:0] dur);
        song_entry_t e;
        e.note = note;
        e.rest = rest;
        e.dur  = dur;
        return e;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between a player front-end (master) and the
// tone sequencer (slave).
//   start, stop  - single-cycle command pulses
//   pause        - level, freezes playback
//   loop_en      - level, wrap to entry 0 at end of song
//   note_sel     - note code to the tone divider
//   tone_en      - audio gate to the tone divider
//   playing      - high while a song is in progress
//   note_idx     - current song ROM entry
//   done         - one-cycle pulse at the natural end of a song
interface tone_sequencer_if #(
    parameter int SONG_LEN = tone_pkg::DEFAULT_SONG_LEN
);
    localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

    logic             start;
    logic             stop;
    logic             pause;
    logic             loop_en;
    logic [2:0]       note_sel;
    logic             tone_en;
    logic             playing;
    logic [IDX_W-1:0] note_idx;
    logic             done;

    modport master (
        output start, stop, pause, loop_en,
        input  note_sel, tone_en, playing, note_idx, done
    );

    modport slave (
        input  start, stop, pause, loop_en,
        output note_sel, tone_en, playing, note_idx, done
    );

endinterface

// File: rtl/tone_sequencer_song_rom.sv
// Combinational song ROM.
//   addr  in   entry index
//   entry out  {note, rest, dur} for that index
// Default melody: an ascending scale do..high do, 250 ms per note,
// terminated by a zero-duration entry.
module tone_song_rom
    import tone_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] addr,
    output song_entry_t      entry
);

    always_comb begin
        entry = make_entry(NOTE_DO, 1'b0, 12'd0);
        case (int'(addr))
            0:       entry = make_entry(NOTE_DO,    1'b0, 12'd250);
            1:       entry = make_entry(NOTE_RE,    1'b0, 12'd250);
            2:       entry = make_entry(NOTE_MI,    1'b0, 12'd250);
            3:       entry = make_entry(NOTE_FA,    1'b0, 12'd250);
            4:       entry = make_entry(NOTE_SOL,   1'b0, 12'd250);
            5:       entry = make_entry(NOTE_LA,    1'b0, 12'd250);
            6:       entry = make_entry(NOTE_TI,    1'b0, 12'd250);
            7:       entry = make_entry(NOTE_DO_HI, 1'b0, 12'd250);
            8:       entry = make_entry(NOTE_DO,    1'b0, 12'd0);
            default: entry = make_entry(NOTE_DO,    1'b0, 12'd0);
        endcase
    end

endmodule

// File: rtl/tone_sequencer.sv
// Autonomous melody controller driving the tone divider from a song ROM.
//   CLK_50M  in   system clock
//   RESET    in   asynchronous active-high reset
//   bus      slave side of tone_sequencer_if (commands in, note/gate/status out)
// Every entry plays for dur ms (gate high unless rest), followed by a silent
// GAP_MS gap with the note held. All outputs are registered.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int SONG_LEN = DEFAULT_SONG_LEN,
    parameter int GAP_MS   = 20
) (
    input  logic           CLK_50M,
    input  logic           RESET,
    tone_sequencer_if.slave bus
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_MS);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SONG_LEN - 1);

    state_t             state_reg, state_next;
    logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic [DUR_W-1:0]   dur_cnt_reg, dur_cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [2:0]         note_reg, note_next;
    logic               rest_reg, rest_next;

    logic [2:0]         note_sel_reg, note_sel_next;
    logic               tone_en_reg, tone_en_next;
    logic               playing_reg, playing_next;
    logic               done_reg, done_next;

    song_entry_t        first_entry, next_entry;
    logic [IDX_W-1:0]   next_addr;
    logic               run, tick, dur_end;
    logic               do_load, do_clear;
    song_entry_t        load_entry;
    logic [IDX_W-1:0]   load_idx;

    // Two ROM ports: entry 0 for start/loop, entry idx+1 for advancing
    // and for spotting the terminator one entry ahead.
    assign next_addr = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

    tone_song_rom #(.IDX_W(IDX_W)) u_rom_first (
        .addr  ('0),
        .entry (first_entry)
    );

    tone_song_rom #(.IDX_W(IDX_W)) u_rom_next (
        .addr  (next_addr),
        .entry (next_entry)
    );

    // Timebase only advances while actively playing and not paused, so a
    // pause freezes both counters exactly where they were.
    assign run     = ((state_reg == ST_PLAY) || (state_reg == ST_GAP)) && !bus.pause;
    assign tick    = run && (tick_cnt_reg == TICK_LAST);
    assign dur_end = tick && (dur_cnt_reg == DUR_ONE);

    // State and datapath registers
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            dur_cnt_reg  <= '0;
            idx_reg      <= '0;
            note_reg     <= '0;
            rest_reg     <= 1'b0;
            note_sel_reg <= '0;
            tone_en_reg  <= 1'b0;
            playing_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            dur_cnt_reg  <= dur_cnt_next;
            idx_reg      <= idx_next;
            note_reg     <= note_next;
            rest_reg     <= rest_next;
            note_sel_reg <= note_sel_next;
            tone_en_reg  <= tone_en_next;
            playing_reg  <= playing_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        dur_cnt_next  = dur_cnt_reg;
        idx_next      = idx_reg;
        note_next     = note_reg;
        rest_next     = rest_reg;
        do_load       = 1'b0;
        do_clear      = 1'b0;
        load_entry    = first_entry;
        load_idx      = '0;

        if (run) begin
            tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick && (dur_cnt_reg != '0)) begin
                dur_cnt_next = dur_cnt_reg - 1'b1;
            end
        end

        if (bus.stop) begin
            state_next = ST_IDLE;
            do_clear   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start && !bus.pause) begin
                        if (first_entry.dur == '0) begin
                            state_next = ST_DONE;
                            do_clear   = 1'b1;
                        end else begin
                            state_next = ST_PLAY;
                            do_load    = 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (dur_end) begin
                        state_next    = ST_GAP;
                        tick_cnt_next = '0;
                        dur_cnt_next  = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (dur_end) begin
                        if ((idx_reg == LAST_IDX) || (next_entry.dur == '0)) begin
                            if (bus.loop_en) begin
                                state_next = ST_PLAY;
                                do_load    = 1'b1;
                            end else begin
                                state_next = ST_DONE;
                                do_clear   = 1'b1;
                            end
                        end else begin
                            state_next = ST_PLAY;
                            do_load    = 1'b1;
                            load_entry = next_entry;
                            load_idx   = next_addr;
                        end
                    end
                end
                ST_DONE: begin
                    // A start arriving here is dropped on purpose.
                    state_next = ST_IDLE;
                    do_clear   = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                    do_clear   = 1'b1;
                end
            endcase
        end

        if (do_clear) begin
            tick_cnt_next = '0;
            dur_cnt_next  = '0;
            idx_next      = '0;
            note_next     = '0;
            rest_next     = 1'b0;
        end
        if (do_load) begin
            tick_cnt_next = '0;
            dur_cnt_next  = load_entry.dur;
            idx_next      = load_idx;
            note_next     = load_entry.note;
            rest_next     = load_entry.rest;
        end
    end

    // Output decode, registered alongside the state
    always_comb begin
        playing_next  = (state_next == ST_PLAY) || (state_next == ST_GAP);
        note_sel_next = playing_next ? note_next : 3'd0;
        tone_en_next  = (state_next == ST_PLAY) && !rest_next && !bus.pause;
        done_next     = (state_next == ST_DONE);
    end

    assign bus.note_sel = note_sel_reg;
    assign bus.tone_en  = tone_en_reg;
    assign bus.playing  = playing_reg;
    assign bus.note_idx = idx_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer (TICK_DIV=10, GAP_MS=2, default ROM).
// Expected per-entry records (index, note, gate-high cycles, silent cycles)
// are queued when a song is started and checked as each entry ends.
module tb_tone_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tone_sequencer_if #(.SONG_LEN(16)) bus ();

    tone_sequencer #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .SONG_LEN (16),
        .GAP_MS   (2)
    ) dut (
        .CLK_50M (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_cycles = 0;

    typedef struct {
        int idx;
        int note;
        int on_cyc;
        int off_cyc;
        bit full;
    } rec_t;

    rec_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic push_rec(input int idx, input int on_cyc, input int off_cyc, input bit full);
        rec_t r;
        r.idx     = idx;
        r.note    = idx;
        r.on_cyc  = on_cyc;
        r.off_cyc = off_cyc;
        r.full    = full;
        exp_q.push_back(r);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idx(input int idx, input int budget, input string tag);
        int n = 0;
        while (int'(bus.note_idx) != idx && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.note_idx, idx);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
    endtask

    task automatic wait_gap(input int budget);
        int n = 0;
        while (!(bus.playing && !bus.tone_en) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("gap_seen", bus.playing && !bus.tone_en, 1);
    endtask

    // Entry monitor: measures each entry and checks it against the queue
    initial begin : monitor
        bit   open = 1'b0;
        int   cur_idx = 0;
        int   cur_note = 0;
        int   on_c = 0;
        int   off_c = 0;
        rec_t e;
        forever begin
            @(negedge clk);
            if (open && (!bus.playing || int'(bus.note_idx) != cur_idx)) begin
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("entry idx=%0d note=%0d on=%0d off=%0d", cur_idx, cur_note, on_c, off_c);
                    check($sformatf("entry%0d_idx", e.idx), cur_idx, e.idx);
                    check($sformatf("entry%0d_note", e.idx), cur_note, e.note);
                    if (e.full) begin
                        check($sformatf("entry%0d_on", e.idx), on_c, e.on_cyc);
                        check($sformatf("entry%0d_off", e.idx), off_c, e.off_cyc);
                    end
                end
                open = 1'b0;
            end
            if (bus.playing) begin
                if (!open) begin
                    open     = 1'b1;
                    cur_idx  = int'(bus.note_idx);
                    cur_note = int'(bus.note_sel);
                    on_c     = 0;
                    off_c    = 0;
                end
                if (bus.tone_en) on_c++;
                else             off_c++;
            end
            if (bus.done) done_cycles++;
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int base_done;
        int hi;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_note_sel", bus.note_sel, 0);
        check("rst_tone_en",  bus.tone_en, 0);
        check("rst_playing",  bus.playing, 0);
        check("rst_note_idx", bus.note_idx, 0);
        check("rst_done",     bus.done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Run A: full song, no loop
        for (int i = 0; i < 8; i++) push_rec(i, 2500, 20, 1'b1);
        base_done = done_cycles;
        pulse_start();
        check("a_first_note", bus.note_sel, 0);
        check("a_first_gate", bus.tone_en, 1);
        check("a_first_play", bus.playing, 1);
        check("a_first_idx",  bus.note_idx, 0);
        wait_done(21000);
        check("a_done_playing", bus.playing, 0);
        check("a_done_idx",     bus.note_idx, 0);
        check("a_done_gate",    bus.tone_en, 0);
        // start coinciding with the DONE cycle must be dropped
        pulse_start();
        check("a_done_width",   bus.done, 0);
        check("a_start_in_done", bus.playing, 0);
        repeat (5) @(negedge clk);
        check("a_still_idle",   bus.playing, 0);
        check("a_done_count",   done_cycles - base_done, 1);
        check("a_queue_empty",  exp_q.size(), 0);

        // Run B: looping with a pause in entry 2, then stop+start in a gap
        bus.loop_en = 1'b1;
        for (int i = 0; i < 8; i++) push_rec(i, 2500, (i == 2) ? 797 : 20, 1'b1);
        push_rec(0, 0, 0, 1'b0);
        base_done = done_cycles;
        pulse_start();
        wait_idx(2, 6000, "b_reach_idx2");
        repeat (999) @(negedge clk);
        bus.pause = 1'b1;
        hi = 0;
        for (int i = 0; i < 777; i++) begin
            @(negedge clk);
            if (bus.tone_en) hi++;
        end
        bus.pause = 1'b0;
        check("b_pause_silent", hi, 0);
        check("b_pause_playing", bus.playing, 1);
        wait_idx(7, 15000, "b_reach_idx7");
        wait_idx(0, 3000, "b_wrap_idx0");
        check("b_wrap_gate",  bus.tone_en, 1);
        check("b_wrap_note",  bus.note_sel, 0);
        check("b_wrap_nodone", bus.done, 0);
        wait_gap(3000);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("b_stop_playing", bus.playing, 0);
        check("b_stop_gate",    bus.tone_en, 0);
        check("b_stop_idx",     bus.note_idx, 0);
        check("b_stop_note",    bus.note_sel, 0);
        repeat (30) @(negedge clk);
        check("b_stop_idle",    bus.playing, 0);
        check("b_no_done",      done_cycles - base_done, 0);
        bus.loop_en = 1'b0;

        // Run C: replay from entry 0, asynchronous reset in the middle of entry 3
        for (int i = 0; i < 3; i++) push_rec(i, 2500, 20, 1'b1);
        push_rec(3, 0, 0, 1'b0);
        base_done = done_cycles;
        pulse_start();
        check("c_replay_idx",  bus.note_idx, 0);
        check("c_replay_gate", bus.tone_en, 1);
        wait_idx(3, 8000, "c_reach_idx3");
        repeat (500) @(negedge clk);
        rst = 1'b1;
        #1;
        check("c_arst_note_sel", bus.note_sel, 0);
        check("c_arst_tone_en",  bus.tone_en, 0);
        check("c_arst_playing",  bus.playing, 0);
        check("c_arst_note_idx", bus.note_idx, 0);
        check("c_arst_done",     bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("c_idle_playing", bus.playing, 0);
        check("c_idle_gate",    bus.tone_en, 0);
        check("c_no_done",      done_cycles - base_done, 0);
        check("c_queue_empty",  exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Autonomous melody controller that sequences the tone-organ datapath. It replaces manual switch selection of the tone.
- Steps through a fixed song ROM. Each entry is a note code, a rest flag and a duration in milliseconds.
- Drives note select and tone enable to the tone divider, with a silent articulation gap between entries.
- Supports start, stop, pause and loop.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 1000: timebase tick rate (1 ms). TICK_DIV = CLK_FREQ/TICK_HZ. CLK_FREQ must be an integer multiple of TICK_HZ.
- SONG_LEN, 16: number of ROM entries. note_idx width = $clog2(SONG_LEN).
- GAP_MS, 20: silent gap between entries, in ticks, 1..4095.

Ports:
- CLK_50M  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins playback from entry 0 when idle.
- stop  in  1  single-cycle pulse; aborts playback.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; wrap to entry 0 instead of finishing.
- note_sel  out  3  note code to tone divider (0=do … 7=high do).
- tone_en  out  1  audio gate to tone divider.
- playing  out  1  high in PLAY or GAP.
- note_idx  out  $clog2(SONG_LEN)  current ROM entry.
- done  out  1  one-cycle pulse at natural end of song.

Behaviour:
- Reset (async, any time, including mid-note):
  - state=IDLE; note_sel=0, tone_en=0, playing=0, note_idx=0, done=0.
  - Tick and duration counters cleared.
- All outputs are registered.
- States: IDLE, PLAY, GAP, DONE.
- Priority when asserted in the same cycle: stop > pause > start.
- Tick generator:
  - Counts 0..TICK_DIV-1 only in PLAY/GAP with pause=0.
  - tick asserts for one cycle when count==TICK_DIV-1, then wraps to 0.
  - Cleared on every state entry.
- IDLE:
  - start=1 → load entry 0 and enter PLAY.
  - From the first edge after start: tone_en = !rest, note_sel = entry.note, playing=1.
- PLAY:
  - dur_cnt loads entry.dur on entry and decrements on tick.
  - On a tick with dur_cnt==1 → GAP. dur_cnt=GAP_MS, tone_en=0, note_sel held.
  - Result: tone_en is high for exactly dur×TICK_DIV cycles, or stays 0 if rest=1.
- GAP:
  - On a tick with dur_cnt==1:
    - If note_idx==SONG_LEN-1, or the next entry has dur==0 (terminator): go to PLAY at entry 0 if loop_en=1, else go to DONE.
    - Otherwise note_idx+1 → PLAY.
- DONE:
  - Lasts one cycle with done=1, then IDLE.
  - note_idx=0, tone_en=0, playing=0.
- Entry 0 with dur==0: start goes directly to DONE.
- pause=1 in PLAY/GAP:
  - Tick and duration counters hold; tone_en forced 0.
  - On release, tone_en is restored and timing resumes where it stopped (no lost or extra cycles).
- stop in any state: IDLE on the next edge, outputs at reset values. No done pulse.
- start while PLAY/GAP: ignored.
- start in the same cycle as the DONE→IDLE transition: ignored. A new start is needed.
- loop_en is sampled only at end-of-song.
- dur field is 12 bits (max 4095 ms). dur_cnt is 12 bits and never underflows.

Decomposition:
- Package tone_pkg:
  - state enum.
  - song-entry struct {note[2:0], rest, dur[11:0]}.
  - note code constants NOTE_DO..NOTE_DO_HI.
  - Default SONG_LEN.
- Sub-module tone_song_rom: combinational case ROM indexed by note_idx, returning the entry struct.
- Default ROM contents:
  - Entries 0–7: notes 0..7, rest=0, dur=250.
  - Entry 8: dur=0 terminator.

Test Plan (CLK_FREQ=1000, TICK_HZ=100 → TICK_DIV=10, GAP_MS=2, default ROM):
- Reset check: RESET pulsed mid-PLAY at entry 3 → all outputs 0 immediately (asynchronous); IDLE after release.
- Basic play: start pulse → note_sel=0, tone_en=1 for exactly 2500 cycles; then tone_en=0 for 20 cycles; then note_sel=1, note_idx=1.
- Natural end: full song, loop_en=0 → done pulses once for 1 cycle after the entry-7 gap; playing falls; note_idx=0.
- Looping: loop_en=1 → after the entry-7 gap, note_idx=0 and tone_en=1 with no done pulse.
- Pause: pause high for 777 cycles at 1000 cycles into entry 2 → tone_en=0 throughout the pause; entry 2 total audible time still 2500 cycles.
- Stop priority: stop+start in the same cycle during GAP → IDLE, tone_en=0, no done; a later start replays from entry 0.
